fp_mul_norm_pack: RTL and testbench

FP_MUL_NORM_PACK -- requirements
Module: fp_mul_norm_pack

---
 rtl/fp_mul_norm_pack.sv | 108 ++++++++++
 tb/tb_fp_mul_norm_pack.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_norm_pack.sv
// Final stage of the FP multiplier: left-normalises the stage-3 product one bit
// per cycle, then packs it into IEEE-754 single precision with ovf/uf/zero flags.
module fp_mul_norm_pack #(
    parameter int MAX_SHIFT = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] c1_m,
    input  logic [7:0]  c1_e,
    input  logic        c1_s,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        ovf,
    output logic        uf,
    output logic        zero,
    output logic [1:0]  dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
    // valid never depends on ready, and payload is held stable while valid && !ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [4:0] MAX_CNT = 5'(MAX_SHIFT);

    state_t      state;
    logic [23:0] m;
    logic [7:0]  e;
    logic        s;
    logic [4:0]  cnt;

    // in_ready is forced low during reset even though state already reads IDLE.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == HOLD);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            result <= 32'h0;
            ovf    <= 1'b0;
            uf     <= 1'b0;
            zero   <= 1'b0;
            m      <= 24'h0;
            e      <= 8'h0;
            s      <= 1'b0;
            cnt    <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m     <= c1_m;
                        e     <= c1_e;
                        s     <= c1_s;
                        cnt   <= 5'd0;
                        ovf   <= 1'b0;
                        uf    <= 1'b0;
                        zero  <= 1'b0;
                        state <= NORM;
                    end
                end
                NORM: begin
                    // One priority rule per cycle; the first match wins.
                    if (m == 24'h0) begin
                        result <= {s, 31'h0};
                        zero   <= 1'b1;
                        state  <= HOLD;
                    end else if (e == 8'hFF) begin
                        result <= {s, 8'hFF, 23'h0};
                        ovf    <= 1'b1;
                        state  <= HOLD;
                    end else if (e == 8'h00) begin
                        result <= {s, 31'h0};
                        uf     <= 1'b1;
                        zero   <= 1'b1;
                        state  <= HOLD;
                    end else if (m[23]) begin
                        result <= {s, e, m[22:0]};
                        state  <= HOLD;
                    end else if (e == 8'h01 || cnt == MAX_CNT) begin
                        // Exponent would underflow, or the shift budget is spent.
                        result <= {s, 31'h0};
                        uf     <= 1'b1;
                        zero   <= 1'b1;
                        state  <= HOLD;
                    end else begin
                        m   <= {m[22:0], 1'b0};
                        e   <= e - 8'd1;
                        cnt <= cnt + 5'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_norm_pack.sv
// Bench for fp_mul_norm_pack: directed corner cases plus random operands checked
// against a leading-zero-count model of normalise-and-pack.
module tb_fp_mul_norm_pack;

    localparam int MAX_SHIFT = 23;

    // clock / reset
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] c1_m = '0;
    logic [7:0]  c1_e = '0;
    logic        c1_s = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic [31:0] result;
    logic        out_valid;
    logic        ovf;
    logic        uf;
    logic        zero;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    fp_mul_norm_pack #(.MAX_SHIFT(MAX_SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .c1_m(c1_m), .c1_e(c1_e), .c1_s(c1_s),
        .in_valid(in_valid), .in_ready(in_ready), .result(result),
        .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf), .uf(uf),
        .zero(zero), .dbg_state(dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: count leading zeros, then decide whether the exponent or the
    // shift budget runs out before the hidden bit reaches position 23.
    task automatic model(input logic [23:0] m, input logic [7:0] e, input logic s,
                         output logic [31:0] r, output logic [2:0] flags, output int lat);
        int lz;
        int ei;
        logic [23:0] mn;
        lz = 24;
        for (int i = 23; i >= 0; i--) begin
            if (m[i] && lz == 24) lz = 23 - i;
        end
        ei = int'(e);
        if (m == 24'h0) begin
            r = {s, 31'h0}; flags = 3'b001; lat = 1;
        end else if (e == 8'hFF) begin
            r = {s, 8'hFF, 23'h0}; flags = 3'b100; lat = 1;
        end else if (e == 8'h00) begin
            r = {s, 31'h0}; flags = 3'b011; lat = 1;
        end else if (lz <= ei - 1 && lz <= MAX_SHIFT) begin
            mn = m << lz;
            r = {s, 8'(ei - lz), mn[22:0]}; flags = 3'b000; lat = 1 + lz;
        end else begin
            r = {s, 31'h0}; flags = 3'b011;
            lat = 1 + ((ei - 1 < MAX_SHIFT) ? ei - 1 : MAX_SHIFT);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check("ready_wait", {31'h0, in_ready}, 32'h1);
    endtask

    task automatic accept(input logic [23:0] m, input logic [7:0] e, input logic s);
        c1_m = m; c1_e = e; c1_s = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    // driver: one full operand, consumed after `hold` stalled cycles
    task automatic run_op(input logic [23:0] m, input logic [7:0] e, input logic s, input int hold);
        logic [31:0] r;
        logic [31:0] exp_r;
        logic [2:0]  fl;
        int          exp_lat;
        int          lat;
        model(m, e, s, r, fl, exp_lat);
        exp_q.push_back(r);
        wait_ready();
        accept(m, e, s);
        wait_out(lat);
        exp_r = exp_q.pop_front();
        check("latency", 32'(lat), 32'(exp_lat));
        check("result", result, exp_r);
        check("flags", {29'h0, ovf, uf, zero}, {29'h0, fl});
        check("busy_ready", {31'h0, in_ready}, 32'h0);
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_result", result, exp_r);
            check("hold_valid", {31'h0, out_valid}, 32'h1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_valid", {31'h0, out_valid}, 32'h0);
        check("drain_ready", {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        int lat;
        logic [23:0] rm;
        logic [7:0]  re;

        // reset state
        #12;
        check("rst_ready", {31'h0, in_ready}, 32'h0);
        check("rst_out", {result, 28'h0, out_valid, ovf, uf, zero} == '0 ? 32'h0 : 32'h1, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", {31'h0, in_ready}, 32'h1);

        // directed corners
        run_op(24'hC00000, 8'h80, 1'b0, 0);
        check("dir_norm", result, 32'h40400000);
        run_op(24'h200000, 8'h82, 1'b1, 1);
        run_op(24'h000001, 8'h10, 1'b0, 0);
        run_op(24'h800000, 8'hFF, 1'b1, 0);
        run_op(24'h000000, 8'h55, 1'b1, 0);
        run_op(24'h400000, 8'h00, 1'b0, 0);
        run_op(24'h400000, 8'h01, 1'b0, 0);
        run_op(24'h400000, 8'h02, 1'b1, 0);
        run_op(24'h000001, 8'h18, 1'b1, 0);

        // backpressure: in_valid held high during HOLD must not be taken early
        wait_ready();
        accept(24'hC00000, 8'h80, 1'b0);
        wait_out(lat);
        c1_m = 24'h800000; c1_e = 8'h7F; c1_s = 1'b0; in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_result", result, 32'h40400000);
            check("bp_ready", {31'h0, in_ready}, 32'h0);
            check("bp_state", {30'h0, dbg_state}, 32'h2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_not_taken", {30'h0, dbg_state}, 32'h0);
        check("bp_ready_up", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(lat);
        check("bp_next_lat", 32'(lat), 32'd1);
        check("bp_next_result", result, 32'h3F800000);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // reset in the middle of a 10-shift operand
        wait_ready();
        accept(24'h002000, 8'h80, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("midrst_out", {result[31:4], out_valid, ovf, uf, zero} == '0 ? 32'h0 : 32'h1, 32'h0);
        check("midrst_result", result, 32'h0);
        check("midrst_ready", {31'h0, in_ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        check("midrst_dropped", {31'h0, out_valid}, 32'h0);
        run_op(24'h002000, 8'h80, 1'b1, 0);

        // random operands with a bias toward the exponent edge cases
        for (int i = 0; i < 200; i++) begin
            rm = 24'($urandom) >> $urandom_range(0, 24);
            case ($urandom_range(0, 7))
                0: re = 8'h00;
                1: re = 8'hFF;
                2: re = 8'($urandom_range(1, 24));
                default: re = 8'($urandom);
            endcase
            run_op(rm, re, 1'($urandom), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
